// File: rtl/mult_float_pipe_pkg.sv
// Shared float definitions: operand classes, flag bit positions and exponent bias.
package mult_float_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fcls_t;

  localparam int unsigned FLAG_W   = 3;
  localparam int unsigned FLAG_INV = 2;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_UNF = 0;

  function automatic int unsigned float_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/mult_float_pipe_if.sv
// Operand/result handshake bundle for the float multiplier.
import mult_float_pipe_pkg::*;

interface mult_float_pipe_if #(
  parameter int FW = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [FW-1:0]     a;
  logic [FW-1:0]     b;
  logic              out_valid;
  logic              out_ready;
  logic [FW-1:0]     m;
  logic [FLAG_W-1:0] flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, m, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, m, flags
  );
endinterface

// File: rtl/mult_mant.sv
// Unsigned W x W mantissa multiplier; purely combinational, the caller registers it.
module mult_mant #(
  parameter int W = 24
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/mult_float_pipe.sv
// 3-stage float multiplier: classify/exponent add, mantissa product, normalize/round/pack.
import mult_float_pipe_pkg::*;

module mult_float_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_float_pipe_if.slave bus
);
  localparam int FW = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int NW = MAN_W + 1;
  localparam int PW = 2 * NW;
  localparam logic [EW-1:0] BIAS = EW'(float_bias(EXP_W));
  localparam logic [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [FW-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  function automatic fcls_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0)      return CLS_ZERO;
    else if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    else              return CLS_NORM;
  endfunction

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fcls_t            ca, cb, c_in;
  logic             inv_in;

  assign {sa, ea, fa} = bus.a;
  assign {sb, eb, fb} = bus.b;

  always_comb begin
    ca     = classify(ea, fa);
    cb     = classify(eb, fb);
    inv_in = 1'b0;
    if (ca == CLS_NAN || cb == CLS_NAN) begin
      c_in = CLS_NAN;
    end else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) begin
      c_in   = CLS_NAN;
      inv_in = 1'b1;
    end else if (ca == CLS_INF || cb == CLS_INF) begin
      c_in = CLS_INF;
    end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
      c_in = CLS_ZERO;
    end else begin
      c_in = CLS_NORM;
    end
  end

  // Stage 1: only valid bits are reset; payload follows valid.
  logic          v1, inv1, sg1;
  fcls_t         c1;
  logic [EW-1:0] e1;
  logic [NW-1:0] ma1, mb1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
    end else if (adv) begin
      v1   <= bus.in_valid;
      c1   <= c_in;
      inv1 <= inv_in;
      sg1  <= sa ^ sb;
      e1   <= {2'b00, ea} + {2'b00, eb} - BIAS;
      ma1  <= {1'b1, fa};
      mb1  <= {1'b1, fb};
    end
  end

  logic [PW-1:0] prod;

  mult_mant #(.W(NW)) u_mant (
    .a (ma1),
    .b (mb1),
    .p (prod)
  );

  logic          v2, inv2, sg2;
  fcls_t         c2;
  logic [EW-1:0] e2;
  logic [PW-1:0] p2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
    end else if (adv) begin
      v2   <= v1;
      c2   <= c1;
      inv2 <= inv1;
      sg2  <= sg1;
      e2   <= e1;
      p2   <= prod;
    end
  end

  // Stage 3: product is in [1,4); drop the leading one, keep MAN_W bits + guard + sticky.
  logic [PW-2:0]       norm;
  logic [MAN_W-1:0]    man;
  logic                guard, sticky, up;
  logic [MAN_W:0]      rnd;
  logic [EW-1:0]       e_r;
  logic [FW-1:0]       nxt_m;
  logic [FLAG_W-1:0]   nxt_f;

  always_comb begin
    norm   = p2[PW-1] ? p2[PW-2:0] : {p2[PW-3:0], 1'b0};
    man    = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    sticky = |norm[MAN_W-1:0];
    up     = guard & (sticky | man[0]);
    rnd    = {1'b0, man} + {{MAN_W{1'b0}}, up};
    e_r    = e2 + {{(EW-1){1'b0}}, p2[PW-1]} + {{(EW-1){1'b0}}, rnd[MAN_W]};
    nxt_m  = '0;
    nxt_f  = '0;
    case (c2)
      CLS_NAN: begin
        nxt_m           = QNAN;
        nxt_f[FLAG_INV] = inv2;
      end
      CLS_INF:  nxt_m = {sg2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: nxt_m = {sg2, {(FW-1){1'b0}}};
      default: begin
        if (e_r[EW-1] || e_r == '0) begin
          nxt_m           = {sg2, {(FW-1){1'b0}}};
          nxt_f[FLAG_UNF] = 1'b1;
        end else if (e_r >= EMAX) begin
          nxt_m           = {sg2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          nxt_f[FLAG_OVF] = 1'b1;
        end else begin
          nxt_m = {sg2, e_r[EXP_W-1:0], rnd[MAN_W-1:0]};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.m         <= '0;
      bus.flags     <= '0;
    end else if (adv) begin
      bus.out_valid <= v2;
      bus.m         <= nxt_m;
      bus.flags     <= nxt_f;
    end
  end

endmodule

// File: tb/tb_mult_float_pipe.sv
// Directed-vector bench for mult_float_pipe at single and half precision.
module tb_mult_float_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] m;
    logic [2:0]  f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mult_float_pipe_if #(.FW(32)) bus ();
  mult_float_pipe_if #(.FW(16)) bus16 ();

  mult_float_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mult_float_pipe #(.EXP_W(5), .MAN_W(10)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;
  int unsigned n_out   = 0;
  vec_t        vecs[$];
  logic [34:0] exp_q[$];
  logic [34:0] cur_exp;
  logic        last_acc;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_m;
  logic [2:0]  hold_f;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples one cycle just after the negedge, then advances to the next negedge.
  task automatic tick();
    logic [34:0] e;
    #1;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("m", bus.m, e[34:3]);
          check("flags", bus.flags, e[2:0]);
        end
      end
      if (hold_pend) begin
        check("hold_m", bus.m, hold_m);
        check("hold_flags", bus.flags, hold_f);
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_m    = bus.m;
      hold_f    = bus.flags;
      check("in_ready", bus.in_ready, !bus.out_valid || bus.out_ready);
      last_acc = bus.in_valid && bus.in_ready;
      if (last_acc) exp_q.push_back(cur_exp);
    end else begin
      exp_q.delete();
      last_acc  = 1'b0;
      hold_pend = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input int i);
    bus.a        = vecs[i].a;
    bus.b        = vecs[i].b;
    cur_exp      = {vecs[i].m, vecs[i].f};
    bus.in_valid = 1'b1;
  endtask

  task automatic half_case(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] m, input logic [2:0] f);
    int unsigned w;
    bus16.a        = a;
    bus16.b        = b;
    bus16.in_valid = 1'b1;
    #1;
    check("h_in_ready", bus16.in_ready, 1);
    tick();
    bus16.in_valid = 1'b0;
    w = 1;
    while (!bus16.out_valid && w < 10) begin
      tick();
      w++;
    end
    check("h_latency", w, 3);
    check("h_m", bus16.m, m);
    check("h_flags", bus16.flags, f);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned lat, cyc, sent, n0;

    vecs.push_back('{32'h40000000, 32'h40400000, 32'h40C00000, 3'b000});
    vecs.push_back('{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000});
    vecs.push_back('{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100});
    vecs.push_back('{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010});
    vecs.push_back('{32'h00800000, 32'h00800000, 32'h00000000, 3'b001});
    vecs.push_back('{32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000});
    vecs.push_back('{32'h7F800000, 32'hC0000000, 32'hFF800000, 3'b000});
    vecs.push_back('{32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b000});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 3'b000});
    vecs.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 3'b000});
    vecs.push_back('{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000});
    vecs.push_back('{32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000});
    vecs.push_back('{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 3'b000});
    vecs.push_back('{32'h7F000000, 32'h3F800000, 32'h7F000000, 3'b000});
    vecs.push_back('{32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 3'b000});
    vecs.push_back('{32'h00800000, 32'h3F000000, 32'h00000000, 3'b001});
    vecs.push_back('{32'hFF800000, 32'h00000000, 32'h7FC00000, 3'b100});

    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.out_ready   = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.out_ready = 1'b1;
    cur_exp         = '0;

    repeat (3) tick();
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_m", bus.m, 0);
    check("rst_flags", bus.flags, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_h_out_valid", bus16.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    present(0);
    tick();
    check("lat_accept", last_acc, 1);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("latency", lat, 3);
    tick();
    check("lat_left", exp_q.size(), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      present(i);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!last_acc && cyc < 20);
      check("stream_accept", last_acc, 1);
    end
    bus.in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("stream_left", exp_q.size(), 0);

    n0   = n_out;
    sent = 0;
    cyc  = 0;
    while ((sent < 5 || exp_q.size() != 0) && cyc < 40) begin
      bus.out_ready = !(cyc >= 3 && cyc < 7);
      if (sent < 5) present(sent);
      else          bus.in_valid = 1'b0;
      if (cyc == 5) begin
        #1;
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_in_ready", bus.in_ready, 0);
      end
      tick();
      if (last_acc) sent++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_sent", sent, 5);
    check("bp_left", exp_q.size(), 0);
    check("bp_outputs", n_out - n0, 5);

    present(0);
    tick();
    check("rst_acc0", last_acc, 1);
    present(1);
    tick();
    check("rst_acc1", last_acc, 1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_m", bus.m, 0);
    n0 = n_out;
    repeat (8) tick();
    check("midrst_no_output", n_out - n0, 0);

    half_case(16'h4000, 16'h4200, 16'h4600, 3'b000);
    half_case(16'h3C00, 16'h3C00, 16'h3C00, 3'b000);
    half_case(16'h7BFF, 16'h4000, 16'h7C00, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/mult_float_pipe.md
MULT_FLOAT_PIPE -- requirements
Module: mult_float_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width in bits.
REQ-002 Parameter MAN_W, default 23, stored mantissa field width in bits (hidden 1 excluded).
REQ-003 Parameter FW, derived as 1+EXP_W+MAN_W (32 at defaults), operand and result width in bits.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  synchronous, active-low reset.
REQ-006 Port in_valid  input  1  operand pair a/b valid this cycle.
REQ-007 Port in_ready  output  1  block accepts operands this cycle.
REQ-008 Port a  input  FW  operand A, format {sign, exp, man}.
REQ-009 Port b  input  FW  operand B, same format.
REQ-010 Port out_valid  output  1  result m/flags valid.
REQ-011 Port out_ready  input  1  consumer accepts the result.
REQ-012 Port m  output  FW  product a*b.
REQ-013 Port flags  output  3  {invalid, overflow, underflow} for the result on m.

Function
REQ-014 The block SHALL be a fixed 3-stage pipeline: S1 unpack/classify/exponent add, S2 mantissa product, S3 normalize/round/pack.
REQ-015 Global advance enable adv = !out_valid || out_ready; all stages load only when adv=1.
REQ-016 in_ready SHALL equal adv, combinationally; a transfer occurs when in_valid && in_ready.
REQ-017 Latency SHALL be exactly 3 adv cycles from accepted input to out_valid=1; throughput is 1 result per cycle while out_ready=1.
REQ-018 Bubbles SHALL propagate as invalid stages; there is no bubble collapsing.
REQ-019 While out_valid=1 and out_ready=0, m and flags SHALL hold stable.
REQ-020 Bias SHALL be 2^(EXP_W-1)-1; raw exponent = expA + expB - bias, computed at EXP_W+2 bits signed.
REQ-021 The mantissa product SHALL be (MAN_W+1)x(MAN_W+1) unsigned with the hidden 1 restored; a product MSB of 1 shifts right 1 and increments the exponent.
REQ-022 Rounding SHALL be round-to-nearest-even using guard bit and sticky OR; a mantissa carry-out renormalizes and increments the exponent.
REQ-023 Sign SHALL be signA XOR signB for all non-NaN results.
REQ-024 Subnormal inputs (exp=0) SHALL be treated as signed zero; zero times a finite value gives signed zero with no flags.
REQ-025 Final exponent >= 2^EXP_W-1 SHALL give signed infinity and overflow=1.
REQ-026 Final exponent <= 0 SHALL flush to signed zero and set underflow=1.
REQ-027 Any NaN input, or infinity times zero, SHALL give the canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0); invalid=1 applies only to infinity times zero.
REQ-028 Infinity times a finite nonzero value SHALL give signed infinity with no flags.

Reset
REQ-029 With rst_n=0 at a clock edge, all stage valid bits SHALL clear; out_valid=0, m=0 and flags=0 on the following cycle.
REQ-030 Reset SHALL discard in-flight operations without producing output, regardless of out_ready.
REQ-031 During reset in_ready SHALL be 1, since out_valid=0; inputs accepted on the reset edge are discarded.

Structure
REQ-032 Bias, class encodings (zero/normal/inf/nan) and the flag bit positions SHALL live in a shared include file used by all float blocks.
REQ-033 The mantissa multiply SHALL be a sub-module mult_mant, parametrised by width (MAN_W+1), purely combinational and registered by the caller.
REQ-034 The RTL SHALL be synthesizable for any EXP_W 5..11 and MAN_W 10..52.

Verification
REQ-035 Basic product at defaults: a=0x40000000, b=0x40400000 with out_ready=1 -> m=0x40C00000, flags=0, 3 cycles after acceptance.
REQ-036 Normalize and round-to-even: 0x3FC00000 x 0x3FC00000 -> 0x40100000; 0x3F800001 x 0x3F800001 -> 0x3F800002.
REQ-037 Special cases: 0x7F800000 x 0x00000000 -> 0x7FC00000 with invalid=1; 0x7F000000 x 0x7F000000 -> 0x7F800000 with overflow=1; 0x00800000 x 0x00800000 -> 0x00000000 with underflow=1.
REQ-038 Backpressure: stream 5 operands back to back, drop out_ready for 4 cycles -> in_ready=0, m held stable, no loss or duplication, results in order.
REQ-039 Reset mid-flight: 2 operands accepted, rst_n=0 for 1 cycle -> out_valid=0 next cycle, and neither result ever appears.
REQ-040 Parametric check: EXP_W=5, MAN_W=10, 0x4000 x 0x4200 -> 0x4600.
